// File: rtl/pwm_pkg.sv
// Shared types and constants for the dead-time PWM comparator slice.
package pwm_pkg;

  // Gate-drive states: both-off, the two dead-time windows, and the two conducting states.
  typedef enum logic [2:0] {
    OFF,
    DT_TO_H,
    H_ON,
    DT_TO_L,
    L_ON
  } pwm_state_e;

  // Dead-time a board typically starts with, in MClk cycles.
  localparam int unsigned DEFAULT_DEAD_TIME = 3;

endpackage

// File: rtl/pwm_valley_detect.sv
// Tracks the triangle carrier direction and flags the sample that turns it
// around at the bottom (valley) or the top (peak). Flat samples never turn it.
module pwm_valley_detect #(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 MClk,
  input  logic                 RstN,
  input  logic [BIT_WIDTH-1:0] TWave,
  output logic                 Valley,
  output logic                 Peak
);

  logic [BIT_WIDTH-1:0] t_prev_q, t_prev_d;
  logic                 dir_down_q, dir_down_d;

  // Compare against the previous sample and flip direction on a turnaround.
  always_comb begin
    Valley     = dir_down_q && (TWave > t_prev_q);
    Peak       = !dir_down_q && (TWave < t_prev_q);
    t_prev_d   = TWave;
    dir_down_d = dir_down_q;
    if (Valley) begin
      dir_down_d = 1'b0;
    end else if (Peak) begin
      dir_down_d = 1'b1;
    end
  end

  // Previous sample and direction registers; reset assumes a rising carrier from 0.
  always_ff @(posedge MClk) begin
    if (!RstN) begin
      t_prev_q   <= '0;
      dir_down_q <= 1'b0;
    end else begin
      t_prev_q   <= t_prev_d;
      dir_down_q <= dir_down_d;
    end
  end

endmodule

// File: rtl/pwm_deadtime_compare.sv
// Carrier/duty comparator driving a complementary gate pair with dead-time,
// valley-aligned double-buffered duty updates and a sticky fault shutdown.
module pwm_deadtime_compare
  import pwm_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int DT_WIDTH  = 8
) (
  input  logic                 MClk,
  input  logic                 RstN,
  input  logic                 En,
  input  logic [BIT_WIDTH-1:0] TWave,
  input  logic [BIT_WIDTH-1:0] DutyIn,
  input  logic                 DutyValid,
  input  logic [DT_WIDTH-1:0]  DeadTime,
  input  logic                 Fault,
  input  logic                 FaultClr,
  output logic                 PwmH,
  output logic                 PwmL,
  output logic                 PeriodStart,
  output logic                 DutyPending,
  output logic                 FaultLatched
);

  logic valley;
  // Peak is not needed here; the detector exports it for ADC trigger alignment.
  logic peak_unused;

  logic [BIT_WIDTH-1:0] shadow_q, shadow_d;
  logic [BIT_WIDTH-1:0] cmp_active_q, cmp_active_d;
  logic                 duty_pending_q, duty_pending_d;
  logic                 raw_q, raw_d;
  logic                 period_start_q, period_start_d;
  logic                 fault_latched_q, fault_latched_d;
  pwm_state_e           state_q, state_d;
  logic [DT_WIDTH-1:0]  dt_cnt_q, dt_cnt_d;
  logic                 pwm_h_q, pwm_h_d;
  logic                 pwm_l_q, pwm_l_d;

  pwm_valley_detect #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_valley (
    .MClk  (MClk),
    .RstN  (RstN),
    .TWave (TWave),
    .Valley(valley),
    .Peak  (peak_unused)
  );

  // Shadow/active duty transfer at valleys, raw compare and the fault latch.
  always_comb begin
    shadow_d        = shadow_q;
    cmp_active_d    = cmp_active_q;
    duty_pending_d  = duty_pending_q;
    if (valley && duty_pending_q) begin
      cmp_active_d   = shadow_q;
      duty_pending_d = 1'b0;
    end
    if (DutyValid) begin
      shadow_d       = DutyIn;
      duty_pending_d = 1'b1;
    end
    raw_d           = (TWave < cmp_active_q);
    period_start_d  = valley;
    fault_latched_d = fault_latched_q;
    if (Fault) begin
      fault_latched_d = 1'b1;
    end else if (FaultClr) begin
      fault_latched_d = 1'b0;
    end
  end

  // Dead-time sequencing; a raw edge that reverses mid-window returns to the side that was on.
  always_comb begin
    state_d  = state_q;
    dt_cnt_d = dt_cnt_q;
    if (Fault || !En) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF: begin
          if (!fault_latched_q) begin
            state_d  = raw_q ? DT_TO_H : DT_TO_L;
            dt_cnt_d = DeadTime;
          end
        end
        DT_TO_H: begin
          if (!raw_q) begin
            state_d = L_ON;
          end else if (dt_cnt_q == '0) begin
            state_d = H_ON;
          end else begin
            dt_cnt_d = dt_cnt_q - DT_WIDTH'(1);
          end
        end
        H_ON: begin
          if (!raw_q) begin
            state_d  = DT_TO_L;
            dt_cnt_d = DeadTime;
          end
        end
        DT_TO_L: begin
          if (raw_q) begin
            state_d = H_ON;
          end else if (dt_cnt_q == '0) begin
            state_d = L_ON;
          end else begin
            dt_cnt_d = dt_cnt_q - DT_WIDTH'(1);
          end
        end
        L_ON: begin
          if (raw_q) begin
            state_d  = DT_TO_H;
            dt_cnt_d = DeadTime;
          end
        end
        default: state_d = OFF;
      endcase
    end
    pwm_h_d = (state_d == H_ON);
    pwm_l_d = (state_d == L_ON);
  end

  // All state registers, cleared together so a reset aborts any dead-time window.
  always_ff @(posedge MClk) begin
    if (!RstN) begin
      shadow_q        <= '0;
      cmp_active_q    <= '0;
      duty_pending_q  <= 1'b0;
      raw_q           <= 1'b0;
      period_start_q  <= 1'b0;
      fault_latched_q <= 1'b0;
      state_q         <= OFF;
      dt_cnt_q        <= '0;
      pwm_h_q         <= 1'b0;
      pwm_l_q         <= 1'b0;
    end else begin
      shadow_q        <= shadow_d;
      cmp_active_q    <= cmp_active_d;
      duty_pending_q  <= duty_pending_d;
      raw_q           <= raw_d;
      period_start_q  <= period_start_d;
      fault_latched_q <= fault_latched_d;
      state_q         <= state_d;
      dt_cnt_q        <= dt_cnt_d;
      pwm_h_q         <= pwm_h_d;
      pwm_l_q         <= pwm_l_d;
    end
  end

  assign PwmH         = pwm_h_q;
  assign PwmL         = pwm_l_q;
  assign PeriodStart  = period_start_q;
  assign DutyPending  = duty_pending_q;
  assign FaultLatched = fault_latched_q;

endmodule

// File: tb/tb_pwm_deadtime_compare.sv
// Directed bench for the dead-time PWM comparator: a vector table for the main
// carrier, short-pulse, enable/fault and reset sequences, plus a duty-extremes run.
module tb_pwm_deadtime_compare;
  import pwm_pkg::*;

  typedef struct {
    logic        rstn;
    logic        en;
    logic        fault;
    logic        clr;
    logic        dv;
    logic [15:0] tw;
    logic [15:0] duty;
    logic [7:0]  dt;
    logic [4:0]  exp;  // {PwmH, PwmL, PeriodStart, DutyPending, FaultLatched}
  } vec_t;

  logic        MClk;
  logic        RstN;
  logic        En;
  logic [15:0] TWave;
  logic [15:0] DutyIn;
  logic        DutyValid;
  logic [7:0]  DeadTime;
  logic        Fault;
  logic        FaultClr;
  logic        PwmH;
  logic        PwmL;
  logic        PeriodStart;
  logic        DutyPending;
  logic        FaultLatched;

  int   checks;
  int   failures;
  vec_t vecs[$];

  pwm_deadtime_compare #(
    .BIT_WIDTH(16),
    .DT_WIDTH (8)
  ) dut (
    .MClk        (MClk),
    .RstN        (RstN),
    .En          (En),
    .TWave       (TWave),
    .DutyIn      (DutyIn),
    .DutyValid   (DutyValid),
    .DeadTime    (DeadTime),
    .Fault       (Fault),
    .FaultClr    (FaultClr),
    .PwmH        (PwmH),
    .PwmL        (PwmL),
    .PeriodStart (PeriodStart),
    .DutyPending (DutyPending),
    .FaultLatched(FaultLatched)
  );

  // Free-running 10-unit clock.
  initial MClk = 1'b0;
  always #5 MClk = ~MClk;

  // Triangle 100,90,..,0,10,..,90 repeating, indexed from cycle 1.
  function automatic logic [15:0] triWave(input int k);
    int p;
    p = (k - 1) % 20;
    if (p <= 10) return 16'(100 - 10 * p);
    return 16'(10 * (p - 10));
  endfunction

  task automatic addVec(input logic r, input logic e, input logic f, input logic c,
                        input logic dv, input int tw, input int duty, input int dt,
                        input logic [4:0] exp);
    vec_t v;
    v.rstn  = r;
    v.en    = e;
    v.fault = f;
    v.clr   = c;
    v.dv    = dv;
    v.tw    = 16'(tw);
    v.duty  = 16'(duty);
    v.dt    = 8'(dt);
    v.exp   = exp;
    vecs.push_back(v);
  endtask

  // Plain running row of the main carrier sequence.
  task automatic addA(input int tw, input logic [4:0] exp);
    addVec(1, 1, 0, 0, 0, tw, 0, DEFAULT_DEAD_TIME, exp);
  endtask

  // Drive one cycle of inputs, let the edge happen, and settle before sampling.
  task automatic applyStimulus(input vec_t v);
    RstN      = v.rstn;
    En        = v.en;
    Fault     = v.fault;
    FaultClr  = v.clr;
    DutyValid = v.dv;
    TWave     = v.tw;
    DutyIn    = v.duty;
    DeadTime  = v.dt;
    @(posedge MClk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [4:0] exp);
    logic [4:0] act;
    act = {PwmH, PwmL, PeriodStart, DutyPending, FaultLatched};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s[%0d] {H,L,PS,DP,FL} got=%b want=%b", name, idx, act, exp);
    end
  endtask

  initial begin
    vec_t v;
    logic [4:0] e;
    checks   = 0;
    failures = 0;
    RstN = 1'b0; En = 1'b0; Fault = 1'b0; FaultClr = 1'b0; DutyValid = 1'b0;
    TWave = '0; DutyIn = '0; DeadTime = '0;

    // Main carrier, DeadTime=3: duty 50 applied at first valley, 80 queued mid-period.
    addVec(0, 1, 0, 0, 0,   0,  0, DEFAULT_DEAD_TIME, 5'b00000);
    addVec(1, 1, 0, 0, 1, 100, 50, DEFAULT_DEAD_TIME, 5'b00010);
    addA( 90, 5'b00010); addA( 80, 5'b00010); addA( 70, 5'b00010);
    addA( 60, 5'b01010); addA( 50, 5'b01010); addA( 40, 5'b01010); addA( 30, 5'b01010);
    addA( 20, 5'b01010); addA( 10, 5'b01010); addA(  0, 5'b01010);
    addA( 10, 5'b01100); addA( 20, 5'b01000);
    addA( 30, 5'b00000); addA( 40, 5'b00000); addA( 50, 5'b00000);
    addA( 60, 5'b01000); addA( 70, 5'b01000); addA( 80, 5'b01000); addA( 90, 5'b01000);
    addA(100, 5'b01000); addA( 90, 5'b01000); addA( 80, 5'b01000); addA( 70, 5'b01000);
    addA( 60, 5'b01000); addA( 50, 5'b01000); addA( 40, 5'b01000);
    addA( 30, 5'b00000); addA( 20, 5'b00000); addA( 10, 5'b00000); addA(  0, 5'b00000);
    addA( 10, 5'b10100); addA( 20, 5'b10000); addA( 30, 5'b10000); addA( 40, 5'b10000);
    addA( 50, 5'b10000);
    addVec(1, 1, 0, 0, 1,  60, 80, DEFAULT_DEAD_TIME, 5'b00010);
    addA( 70, 5'b00010); addA( 80, 5'b00010); addA( 90, 5'b00010);
    addA(100, 5'b01010); addA( 90, 5'b01010); addA( 80, 5'b01010); addA( 70, 5'b01010);
    addA( 60, 5'b01010); addA( 50, 5'b01010); addA( 40, 5'b01010);
    addA( 30, 5'b00010); addA( 20, 5'b00010); addA( 10, 5'b00010); addA(  0, 5'b00010);
    addA( 10, 5'b10100); addA( 20, 5'b10000); addA( 30, 5'b10000); addA( 40, 5'b10000);
    addA( 50, 5'b10000); addA( 60, 5'b10000); addA( 70, 5'b10000); addA( 80, 5'b10000);
    addA( 90, 5'b00000);

    // Short pulse: duty 15, DeadTime=5, raw high only for samples 12 and 8.
    addVec(0, 1, 0, 0, 0,   0,  0, 5, 5'b00000);
    addVec(1, 1, 0, 0, 1, 100, 15, 5, 5'b00010);
    addVec(1, 1, 0, 0, 0,  80,  0, 5, 5'b00010);
    addVec(1, 1, 0, 0, 0,  60,  0, 5, 5'b00010);
    addVec(1, 1, 0, 0, 0,  40,  0, 5, 5'b00010);
    addVec(1, 1, 0, 0, 0,  20,  0, 5, 5'b00010);
    addVec(1, 1, 0, 0, 0,   0,  0, 5, 5'b00010);
    addVec(1, 1, 0, 0, 0,  20,  0, 5, 5'b01100);
    addVec(1, 1, 0, 0, 0,  40,  0, 5, 5'b01000);
    addVec(1, 1, 0, 0, 0,  60,  0, 5, 5'b01000);
    addVec(1, 1, 0, 0, 0,  80,  0, 5, 5'b01000);
    addVec(1, 1, 0, 0, 0, 100,  0, 5, 5'b01000);
    addVec(1, 1, 0, 0, 0,  80,  0, 5, 5'b01000);
    addVec(1, 1, 0, 0, 0,  60,  0, 5, 5'b01000);
    addVec(1, 1, 0, 0, 0,  40,  0, 5, 5'b01000);
    addVec(1, 1, 0, 0, 0,  20,  0, 5, 5'b01000);
    addVec(1, 1, 0, 0, 0,  12,  0, 5, 5'b01000);
    addVec(1, 1, 0, 0, 0,   8,  0, 5, 5'b00000);
    addVec(1, 1, 0, 0, 0,  20,  0, 5, 5'b00100);
    addVec(1, 1, 0, 0, 0,  40,  0, 5, 5'b01000);
    addVec(1, 1, 0, 0, 0,  60,  0, 5, 5'b01000);
    addVec(1, 1, 0, 0, 0,  80,  0, 5, 5'b01000);

    // Enable drop, fault latch/clear, valley+strobe collision, reset inside DT_TO_L.
    addVec(0, 1, 0, 0, 0,  0,   0, 2, 5'b00000);
    addVec(1, 1, 0, 0, 1, 10, 200, 2, 5'b00010);
    addVec(1, 1, 0, 0, 0,  0,   0, 2, 5'b00010);
    addVec(1, 1, 0, 0, 0, 10,   0, 2, 5'b00100);
    addVec(1, 1, 0, 0, 0, 10,   0, 2, 5'b01000);
    addVec(1, 1, 0, 0, 0, 10,   0, 2, 5'b00000);
    addVec(1, 1, 0, 0, 0, 10,   0, 2, 5'b00000);
    addVec(1, 1, 0, 0, 0, 10,   0, 2, 5'b00000);
    addVec(1, 1, 0, 0, 0, 10,   0, 2, 5'b10000);
    addVec(1, 1, 0, 0, 0, 10,   0, 2, 5'b10000);
    addVec(1, 0, 0, 0, 0, 10,   0, 2, 5'b00000);
    addVec(1, 1, 0, 0, 0, 10,   0, 2, 5'b00000);
    addVec(1, 1, 0, 0, 0, 10,   0, 2, 5'b00000);
    addVec(1, 1, 0, 0, 0, 10,   0, 2, 5'b00000);
    addVec(1, 1, 0, 0, 0, 10,   0, 2, 5'b10000);
    addVec(1, 1, 0, 0, 0, 10,   0, 2, 5'b10000);
    addVec(1, 1, 1, 0, 0, 10,   0, 2, 5'b00001);
    addVec(1, 1, 0, 0, 0, 10,   0, 2, 5'b00001);
    addVec(1, 1, 0, 0, 0, 10,   0, 2, 5'b00001);
    addVec(1, 1, 1, 1, 0, 10,   0, 2, 5'b00001);
    addVec(1, 1, 0, 1, 0, 10,   0, 2, 5'b00000);
    addVec(1, 1, 0, 0, 0, 10,   0, 2, 5'b00000);
    addVec(1, 1, 0, 0, 0, 10,   0, 2, 5'b00000);
    addVec(1, 1, 0, 0, 0, 10,   0, 2, 5'b00000);
    addVec(1, 1, 0, 0, 0, 10,   0, 2, 5'b10000);
    addVec(1, 1, 0, 0, 1,  0,   5, 3, 5'b10010);
    addVec(1, 1, 0, 0, 1, 10, 200, 3, 5'b10110);
    addVec(1, 1, 0, 0, 0, 10,   0, 3, 5'b10010);
    addVec(1, 1, 0, 0, 0, 10,   0, 3, 5'b00010);
    addVec(1, 1, 0, 0, 0, 10,   0, 3, 5'b00010);
    addVec(0, 1, 0, 0, 0, 10,   0, 3, 5'b00000);
    addVec(1, 1, 0, 0, 0, 10,   0, 3, 5'b00000);
    addVec(1, 1, 0, 0, 0, 10,   0, 3, 5'b00000);
    addVec(1, 1, 0, 0, 0, 10,   0, 3, 5'b00000);
    addVec(1, 1, 0, 0, 0, 10,   0, 3, 5'b00000);
    addVec(1, 1, 0, 0, 0, 10,   0, 3, 5'b01000);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput("vec", i, vecs[i].exp);
    end

    // Duty extremes, DeadTime=2: 200 holds PwmH solid, then 0 holds PwmL solid.
    for (int k = 0; k <= 60; k++) begin
      v.rstn  = (k != 0);
      v.en    = 1'b1;
      v.fault = 1'b0;
      v.clr   = 1'b0;
      v.dv    = (k == 1) || (k == 20);
      v.duty  = (k == 1) ? 16'd200 : 16'd0;
      v.tw    = (k == 0) ? 16'd0 : triWave(k);
      v.dt    = 8'd2;
      e = 5'b00000;
      if (k >= 4 && k <= 13)       e[4:3] = 2'b01;
      else if (k >= 17 && k <= 33) e[4:3] = 2'b10;
      else if (k >= 37)            e[4:3] = 2'b01;
      e[2] = (k == 12) || (k == 32) || (k == 52);
      e[1] = (k >= 1 && k <= 11) || (k >= 20 && k <= 31);
      v.exp = e;
      applyStimulus(v);
      checkOutput("extremes", k, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime_compare.md
Name: pwm_deadtime_compare

Overview:
- Consumes the triangle-wave carrier (TWave) and a duty reference, and produces a complementary high/low gate-drive PWM pair with programmable dead-time.
- Sits directly downstream of the triangle-wave generator, on the same MClk.
- Duty updates are double-buffered and take effect only at a carrier valley, so every carrier period is glitch-free.
- Includes a sticky fault shutdown.

Parameters:
- BIT_WIDTH, 16, width of carrier and duty values.
- DT_WIDTH, 8, width of dead-time count.

Ports:
- MClk  in  1  clock; all logic on posedge.
- RstN  in  1  reset, synchronous, active-low; clock MClk.
- En  in  1  block enable; low forces both outputs off.
- TWave  in  BIT_WIDTH  carrier sample from the triangle generator, one per cycle.
- DutyIn  in  BIT_WIDTH  new compare value.
- DutyValid  in  1  one-cycle strobe; captures DutyIn into the shadow register.
- DeadTime  in  DT_WIDTH  dead-time length in MClk cycles; sampled at each dead-time entry.
- Fault  in  1  synchronous fault request, active-high.
- FaultClr  in  1  clears latched fault.
- PwmH  out  1  high-side gate.
- PwmL  out  1  low-side gate.
- PeriodStart  out  1  one-cycle pulse at each detected valley.
- DutyPending  out  1  shadow holds a value not yet applied.
- FaultLatched  out  1  sticky fault flag.

Behaviour:
- Reset (RstN=0 at posedge): PwmH=0, PwmL=0, PeriodStart=0, DutyPending=0, FaultLatched=0; CmpActive=0, shadow=0, TPrev=0, Dir=up; FSM=OFF, dead-time counter=0. Reset mid-dead-time aborts immediately.
- Valley detection:
  - TPrev and Dir are registered each cycle.
  - Valley = (Dir==down) && (TWave > TPrev). On a valley, Dir <= up.
  - Peak = (Dir==up) && (TWave < TPrev). On a peak, Dir <= down.
  - TWave==TPrev: no direction change (covers StepSize=0).
  - PeriodStart is registered and asserts the cycle after the valley sample.
- Duty buffering:
  - DutyValid loads shadow and sets DutyPending; later strobes overwrite the shadow (last wins).
  - At a valley with DutyPending=1: CmpActive <= shadow, DutyPending <= 0.
  - Valley and DutyValid in the same cycle: the old shadow goes to CmpActive; the new value is stored in shadow and DutyPending stays 1.
- Raw compare:
  - Raw <= (TWave < CmpActive), registered. Unsigned, full BIT_WIDTH, no overflow.
  - CmpActive=0 gives Raw constantly 0.
  - CmpActive > max carrier gives Raw constantly 1.
- Dead-time FSM (states OFF, DT_TO_H, H_ON, DT_TO_L, L_ON); outputs registered from state:
  - OFF: PwmH=PwmL=0. When En && !FaultLatched, go to DT_TO_H if Raw=1, else DT_TO_L; load counter=DeadTime.
  - DT_TO_H: both outputs 0. Counter decrements; at 0 go to H_ON. If Raw falls, go to L_ON directly, since H was never on.
  - H_ON: PwmH=1. On Raw=0, go to DT_TO_L with counter=DeadTime.
  - DT_TO_L: symmetric to DT_TO_H; at 0 go to L_ON; if Raw rises, go to H_ON directly.
  - L_ON: PwmL=1. On Raw=1, go to DT_TO_H with counter=DeadTime.
  - DeadTime=0: the DT state lasts exactly 1 cycle with both outputs off. Both outputs are never 1 simultaneously.
- Dead-time length: DeadTime=N gives N+1 cycles with both outputs off between an X_ON exit and the opposite Y_ON entry.
- Latency: TWave sample to PwmH/PwmL change = 2 cycles + dead-time.
- En=0: FSM goes to OFF next cycle (outputs 0). Duty logic and valley tracking keep running.
- Fault:
  - Fault=1 sets FaultLatched, and the FSM goes to OFF in the same posedge, overriding everything.
  - FaultClr clears FaultLatched only when Fault=0; Fault wins when both are asserted.
  - After clear, re-entry from OFF follows the OFF rules above, with full dead-time.

Decomposition:
- Shared package pwm_pkg: pwm_state_e enum (OFF, DT_TO_H, H_ON, DT_TO_L, L_ON) and a localparam for the default dead-time.
- One natural sub-module, pwm_valley_detect: TPrev/Dir tracking, emitting valley/peak pulses. It is reusable for ADC trigger alignment.
- FSM, duty buffering and fault logic stay in the top.

Test Plan:
- Reset, then carrier 0..100 step 10, DutyIn=50 before the first valley, DeadTime=3:
  - Shadow applies at the first valley.
  - PwmH high while TWave∈{0..40} (delayed by 2 cycles + dead-time), PwmL high for TWave≥50.
  - Exactly 4 both-off cycles at each edge.
- Mid-period duty change: DutyValid with 80 while TWave=60 rising:
  - CmpActive stays 50 until the next valley; DutyPending=1 until then.
  - PeriodStart pulses once per 20-cycle period.
- Duty extremes:
  - DutyIn=0: PwmL constantly 1, PwmH 0.
  - DutyIn=200: PwmH constantly 1.
  - No spurious dead-time toggles in either case.
- Short pulse: DutyIn=15, DeadTime=5:
  - Raw is high for 2 cycles, shorter than the dead-time.
  - FSM goes DT_TO_H and back to L_ON; PwmH never asserts; PwmL off for 2 cycles.
- Fault:
  - Fault pulse while in H_ON: both outputs 0 at the next edge; FaultLatched=1 persists after Fault drops.
  - FaultClr: resumes via the dead-time state.
  - Fault and FaultClr together: latch stays 1.
- Reset asserted during DT_TO_L (counter=2): all outputs 0 next edge; CmpActive=0, DutyPending=0.
